dsk_nibblizer: RTL and testbench
================================

DSK_NIBBLIZER -- requirements
Module: dsk_nibblizer

Interface
REQ-001 SHALL have no parameters; layout constants fixed by REQ-012.
REQ-002 clk_sys  in  1  system clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to encode one track; honoured only when idle.
REQ-005 track  in  6  track number, latched on accepted start.
REQ-006 volume  in  8  volume number, latched on accepted start.
REQ-007 po_order  in  1  0=DOS 3.3 sector order, 1=ProDOS order; latched on accepted start.
REQ-008 src_addr  out  12  read address into 4096-byte source track buffer (logical sector*256+byte).
REQ-009 src_data  in  8  source byte; valid the cycle after src_addr is presented.
REQ-010 nib_addr/nib_data/nib_we  out  13/8/1  track RAM write port; write occurs on cycles with nib_we=1.
REQ-011 busy/done  out  1/1  busy high from the cycle after accepted start until done; done a one-cycle pulse.

Function
REQ-012 SHALL produce 6656 bytes (16 physical sectors x 416), physical sector p at base p*416; per-sector offsets: 0-44 FF; 45-47 D5 AA 96; 48-55 volume, track, p, checksum (vol^trk^p), each 4-and-4; 56-58 DE AA EB; 59-66 FF; 67-69 D5 AA AD; 70-411 342 data nibbles; 412 data checksum; 413-415 DE AA EB.
REQ-013 4-and-4 SHALL encode v as (v>>1)|0xAA then v|0xAA.
REQ-014 Physical p SHALL read logical sector DOS[p]={0,7,14,6,13,5,12,4,11,3,10,2,9,1,8,15} or PO[p]={0,8,1,9,2,10,3,11,4,12,5,13,6,14,7,15}.
REQ-015 With rev(x)={x[0],x[1]}, b = 256 logical bytes: aux[i]=rev(b[i+172])<<4 | rev(b[i+86])<<2 | rev(b[i]), i=0..85, term zero where i+172>=256.
REQ-016 v[0..85]=aux[0..85], v[86+j]=b[j]>>2; data nibble k = T[v[k]^v[k-1]] with v[-1]=0; checksum = T[v[341]].
REQ-017 T SHALL be the standard 64-entry 6-and-2 write table (T[0]=96, T[1]=97, T[2]=9A, ..., T[63]=FF).
REQ-018 States: IDLE, LOAD (copy 256 source bytes to internal buffer), EMIT (416 bytes), NEXT (p+1, or DONE after p=15), DONE (pulse done, return IDLE).
REQ-019 Writes SHALL be in strictly ascending address order 0..6655, each address exactly once, at most one per cycle; gaps allowed.
REQ-020 Complete track SHALL finish within 11000 cycles of accepted start.
REQ-021 start while busy SHALL be ignored; track/volume/po_order changes mid-operation have no effect.
REQ-022 done SHALL assert exactly one cycle after the write to 6655; busy drops the same cycle; start accepted again the next cycle.
REQ-023 Simultaneous start and done cycle: start ignored.

Reset
REQ-024 Reset SHALL force IDLE, busy=0, done=0, nib_we=0, nib_addr=0, src_addr=0, mid-track included; no writes follow until a new start.
REQ-025 Released reset SHALL accept start on the first clock edge.

Verification
REQ-026 All-zero source, track 0, vol 254, DOS: offsets 45-58 = D5 AA 96 FF FE AA AA AA AA FF FE DE AA EB; offsets 70-412 all 96.
REQ-027 Same, sector 1 (base 416): sec bytes AA AB, checksum FF FF; source reads for p=1 span 0x700-0x7FF (DOS) and 0x800-0x8FF (po_order=1).
REQ-028 src[0]=01, rest 0: track bytes 70,71 = 9A 9A, 72-412 = 96; src[0]=FC instead: bytes 156,157 = FF FF, 412 = 96.
REQ-029 Count nib_we: exactly 6656 writes, addresses 0..6655 ascending, done single pulse, done within 11000 cycles.
REQ-030 reset asserted at write 3000: nib_we low immediately, busy=0, no later writes; restart produces full correct track.
REQ-031 start pulsed while busy with track=5: ignored; output track field still original value.

Source files
------------

// File: rtl/dsk_nibblizer.sv
// Disk track nibblizer: turns a 4096-byte logical track image into a
// 6656-byte GCR-encoded (6-and-2) track, written one byte per cycle into a track RAM.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; latches track/volume/order on accept
// LOAD  | copies 256 bytes of the current logical sector into sec_buf
// EMIT  | produces the 416 bytes of the current physical sector
// NEXT  | advances to the next physical sector, or finishes after p=15
// DONE  | one-cycle done pulse, back to IDLE
module dsk_nibblizer (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  track,
    input  logic [7:0]  volume,
    input  logic        po_order,
    output logic [11:0] src_addr,
    input  logic [7:0]  src_data,
    output logic [12:0] nib_addr,
    output logic [7:0]  nib_data,
    output logic        nib_we,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [7:0] GCR_TAB [64] = '{
        8'h96, 8'h97, 8'h9A, 8'h9B, 8'h9D, 8'h9E, 8'h9F, 8'hA6,
        8'hA7, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF, 8'hB2, 8'hB3,
        8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB9, 8'hBA, 8'hBB, 8'hBC,
        8'hBD, 8'hBE, 8'hBF, 8'hCB, 8'hCD, 8'hCE, 8'hCF, 8'hD3,
        8'hD6, 8'hD7, 8'hD9, 8'hDA, 8'hDB, 8'hDC, 8'hDD, 8'hDE,
        8'hDF, 8'hE5, 8'hE6, 8'hE7, 8'hE9, 8'hEA, 8'hEB, 8'hEC,
        8'hED, 8'hEE, 8'hEF, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6,
        8'hF7, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF
    };

    localparam logic [3:0] DOS_MAP [16] = '{
        4'd0, 4'd7, 4'd14, 4'd6, 4'd13, 4'd5, 4'd12, 4'd4,
        4'd11, 4'd3, 4'd10, 4'd2, 4'd9, 4'd1, 4'd8, 4'd15
    };

    localparam logic [3:0] PO_MAP [16] = '{
        4'd0, 4'd8, 4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11,
        4'd4, 4'd12, 4'd5, 4'd13, 4'd6, 4'd14, 4'd7, 4'd15
    };

    // Low two bits of a byte go into the aux nibble bit-reversed.
    function automatic logic [1:0] swap2(input logic [1:0] x);
        return {x[0], x[1]};
    endfunction

    state_t      state_q, state_d;
    logic [8:0]  cnt_q;
    logic [3:0]  phys_q;
    logic [12:0] base_q;
    logic [5:0]  trk_q;
    logic [7:0]  vol_q;
    logic        po_q;
    logic [5:0]  vprev_q;
    logic [7:0]  sec_buf [256];

    logic [3:0]  log_sec;
    logic [8:0]  k;
    logic [7:0]  ia;
    logic [7:0]  jb;
    logic [1:0]  b_lo, b_mid, b_hi;
    logic [5:0]  b_top;
    logic [5:0]  v_cur;
    logic [7:0]  hdr_val;
    logic [7:0]  hdr_chk;
    logic [7:0]  byte_cur;

    // State register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and status outputs; start in DONE deliberately falls through to IDLE.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: begin
                busy = 1'b1;
                if (cnt_q == 9'd256) state_d = S_EMIT;
            end
            S_EMIT: begin
                busy = 1'b1;
                if (cnt_q == 9'd415) state_d = S_NEXT;
            end
            S_NEXT: begin
                busy = 1'b1;
                state_d = (phys_q == 4'd15) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Source address: logical sector in the top nibble, byte index below it.
    always_comb begin
        log_sec  = po_q ? PO_MAP[phys_q] : DOS_MAP[phys_q];
        src_addr = 12'd0;
        if (state_q == S_LOAD) src_addr = {log_sec, cnt_q[7:0]};
    end

    // Sector buffer fill; data arrives one cycle behind its address, hence cnt-1.
    always_ff @(posedge clk_sys) begin
        if (state_q == S_LOAD && cnt_q != 9'd0) sec_buf[cnt_q[7:0] - 8'd1] <= src_data;
    end

    // 6-bit pre-nibble v[k]: aux groups for k<86, top six bits of b[k-86] after.
    always_comb begin
        k     = cnt_q - 9'd70;
        ia    = k[7:0];
        jb    = k[7:0] - 8'd86;
        b_lo  = sec_buf[ia][1:0];
        b_mid = sec_buf[ia + 8'd86][1:0];
        b_hi  = (ia < 8'd84) ? sec_buf[ia + 8'd172][1:0] : 2'b00;
        b_top = sec_buf[jb][7:2];
        v_cur = (k < 9'd86) ? {swap2(b_hi), swap2(b_mid), swap2(b_lo)} : b_top;
    end

    // Byte for the current sector offset.
    always_comb begin
        hdr_chk = vol_q ^ {2'b00, trk_q} ^ {4'b0000, phys_q};
        case (cnt_q[2:1])
            2'd0:    hdr_val = vol_q;
            2'd1:    hdr_val = {2'b00, trk_q};
            2'd2:    hdr_val = {4'b0000, phys_q};
            default: hdr_val = hdr_chk;
        endcase

        byte_cur = 8'hFF;
        if (cnt_q < 9'd45)        byte_cur = 8'hFF;
        else if (cnt_q == 9'd45)  byte_cur = 8'hD5;
        else if (cnt_q == 9'd46)  byte_cur = 8'hAA;
        else if (cnt_q == 9'd47)  byte_cur = 8'h96;
        else if (cnt_q < 9'd56)   byte_cur = cnt_q[0] ? (hdr_val | 8'hAA)
                                                      : ((hdr_val >> 1) | 8'hAA);
        else if (cnt_q == 9'd56)  byte_cur = 8'hDE;
        else if (cnt_q == 9'd57)  byte_cur = 8'hAA;
        else if (cnt_q == 9'd58)  byte_cur = 8'hEB;
        else if (cnt_q < 9'd67)   byte_cur = 8'hFF;
        else if (cnt_q == 9'd67)  byte_cur = 8'hD5;
        else if (cnt_q == 9'd68)  byte_cur = 8'hAA;
        else if (cnt_q == 9'd69)  byte_cur = 8'hAD;
        else if (cnt_q < 9'd412)  byte_cur = GCR_TAB[v_cur ^ vprev_q];
        else if (cnt_q == 9'd412) byte_cur = GCR_TAB[vprev_q];
        else if (cnt_q == 9'd413) byte_cur = 8'hDE;
        else if (cnt_q == 9'd414) byte_cur = 8'hAA;
        else                      byte_cur = 8'hEB;
    end

    // Datapath: counters, latched parameters and the registered write port.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q    <= 9'd0;
            phys_q   <= 4'd0;
            base_q   <= 13'd0;
            trk_q    <= 6'd0;
            vol_q    <= 8'd0;
            po_q     <= 1'b0;
            vprev_q  <= 6'd0;
            nib_we   <= 1'b0;
            nib_addr <= 13'd0;
            nib_data <= 8'd0;
        end else begin
            nib_we <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        trk_q  <= track;
                        vol_q  <= volume;
                        po_q   <= po_order;
                        phys_q <= 4'd0;
                        base_q <= 13'd0;
                        cnt_q  <= 9'd0;
                    end
                end
                S_LOAD: begin
                    vprev_q <= 6'd0;
                    cnt_q   <= (cnt_q == 9'd256) ? 9'd0 : cnt_q + 9'd1;
                end
                S_EMIT: begin
                    nib_we   <= 1'b1;
                    nib_addr <= base_q + {4'b0000, cnt_q};
                    nib_data <= byte_cur;
                    if (cnt_q >= 9'd70 && cnt_q < 9'd412) vprev_q <= v_cur;
                    cnt_q <= (cnt_q == 9'd415) ? 9'd0 : cnt_q + 9'd1;
                end
                S_NEXT: begin
                    phys_q <= phys_q + 4'd1;
                    base_q <= base_q + 13'd416;
                    cnt_q  <= 9'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dsk_nibblizer.sv
// Bench for dsk_nibblizer: a reference encoder fills a scoreboard of expected
// (address, byte) writes at each start; writes are popped and compared as they appear.
module tb_dsk_nibblizer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  track;
    logic [7:0]  volume;
    logic        po_order;
    logic [11:0] src_addr;
    logic [7:0]  src_data;
    logic [12:0] nib_addr;
    logic [7:0]  nib_data;
    logic        nib_we;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [12:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t        exp_q [$];
    logic [3:0]  lsq [$];
    logic [7:0]  src_mem [4096];
    logic [7:0]  trk_mem [6656];
    logic [11:0] addr_s = 12'd0;
    int          n_checks = 0;
    int          n_pass = 0;

    logic [7:0] gcr_tab [64] = '{
        8'h96, 8'h97, 8'h9A, 8'h9B, 8'h9D, 8'h9E, 8'h9F, 8'hA6,
        8'hA7, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF, 8'hB2, 8'hB3,
        8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB9, 8'hBA, 8'hBB, 8'hBC,
        8'hBD, 8'hBE, 8'hBF, 8'hCB, 8'hCD, 8'hCE, 8'hCF, 8'hD3,
        8'hD6, 8'hD7, 8'hD9, 8'hDA, 8'hDB, 8'hDC, 8'hDD, 8'hDE,
        8'hDF, 8'hE5, 8'hE6, 8'hE7, 8'hE9, 8'hEA, 8'hEB, 8'hEC,
        8'hED, 8'hEE, 8'hEF, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6,
        8'hF7, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF
    };
    int dos_tab [16] = '{0, 7, 14, 6, 13, 5, 12, 4, 11, 3, 10, 2, 9, 1, 8, 15};
    int po_tab  [16] = '{0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15};

    dsk_nibblizer dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .start    (start),
        .track    (track),
        .volume   (volume),
        .po_order (po_order),
        .src_addr (src_addr),
        .src_data (src_data),
        .nib_addr (nib_addr),
        .nib_data (nib_data),
        .nib_we   (nib_we),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_sys = ~clk_sys;

    // Source buffer: data for the address seen in one cycle appears in the next.
    always @(negedge clk_sys) addr_s = src_addr;
    always @(posedge clk_sys) begin
        #1;
        src_data = src_mem[addr_s];
    end

    function automatic logic [1:0] sw(input logic [7:0] x);
        return {x[0], x[1]};
    endfunction

    // Reference encoder: whole track into exp_q, in write order.
    task automatic build_expected(input logic [5:0] t, input logic [7:0] vl, input logic p_o);
        logic [7:0] b [256];
        logic [5:0] v [342];
        logic [7:0] sec [416];
        logic [7:0] fv [4];
        logic [5:0] hi;
        int ls;
        exp_t e;
        exp_q.delete();
        for (int p = 0; p < 16; p++) begin
            ls = p_o ? po_tab[p] : dos_tab[p];
            for (int i = 0; i < 256; i++) b[i] = src_mem[ls * 256 + i];
            for (int i = 0; i < 86; i++) begin
                hi = 6'd0;
                if (i + 172 < 256) hi = {2'b00, sw(b[i + 172]), 2'b00} << 2;
                v[i] = hi | {2'b00, sw(b[i + 86]), 2'b00} | {4'b0000, sw(b[i])};
            end
            for (int j = 0; j < 256; j++) v[86 + j] = b[j][7:2];
            for (int o = 0; o < 416; o++) sec[o] = 8'hFF;
            sec[45] = 8'hD5; sec[46] = 8'hAA; sec[47] = 8'h96;
            fv[0] = vl;
            fv[1] = {2'b00, t};
            fv[2] = 8'(p);
            fv[3] = vl ^ {2'b00, t} ^ 8'(p);
            for (int f = 0; f < 4; f++) begin
                sec[48 + 2 * f] = (fv[f] >> 1) | 8'hAA;
                sec[49 + 2 * f] = fv[f] | 8'hAA;
            end
            sec[56] = 8'hDE; sec[57] = 8'hAA; sec[58] = 8'hEB;
            sec[67] = 8'hD5; sec[68] = 8'hAA; sec[69] = 8'hAD;
            sec[70] = gcr_tab[v[0]];
            for (int q = 1; q < 342; q++) sec[70 + q] = gcr_tab[v[q] ^ v[q - 1]];
            sec[412] = gcr_tab[v[341]];
            sec[413] = 8'hDE; sec[414] = 8'hAA; sec[415] = 8'hEB;
            for (int o = 0; o < 416; o++) begin
                e.a = 13'(p * 416 + o);
                e.d = sec[o];
                exp_q.push_back(e);
            end
        end
    endtask

    // Run one full track from a negedge in IDLE; returns at a negedge in IDLE.
    task automatic do_track(input logic [5:0] t, input logic [7:0] vl, input logic p_o,
                            input bit poke_mid, input bit poke_done);
        exp_t e;
        int cycles, errs, n_wr, last_we;
        bit got_done;
        logic busy1, busy_d;
        logic [12:0] bad_a, bad_ea;
        logic [7:0] bad_d, bad_ed;
        build_expected(t, vl, p_o);
        lsq.delete();
        for (int i = 0; i < 6656; i++) trk_mem[i] = 8'h00;
        bad_a = '0; bad_ea = '0; bad_d = '0; bad_ed = '0;
        track = t; volume = vl; po_order = p_o; start = 1'b1;
        @(posedge clk_sys);
        #1;
        start = 1'b0; track = 6'($urandom); volume = 8'($urandom); po_order = ~p_o;
        cycles = 0; errs = 0; n_wr = 0; last_we = -1; got_done = 0; busy1 = 1'b0; busy_d = 1'b1;
        while (!got_done && cycles < 12000) begin
            @(negedge clk_sys);
            cycles++;
            start = poke_mid && (cycles == 100);
            if (start) track = 6'd5;
            if (cycles == 1) busy1 = busy;
            if (busy && src_addr[7:0] == 8'hFF) lsq.push_back(src_addr[11:8]);
            if (nib_we) begin
                n_wr++;
                last_we = cycles;
                trk_mem[nib_addr] = nib_data;
                if (exp_q.size() == 0) begin
                    if (errs == 0) begin bad_a = nib_addr; bad_d = nib_data; end
                    errs++;
                end else begin
                    e = exp_q.pop_front();
                    if (nib_addr !== e.a || nib_data !== e.d) begin
                        if (errs == 0) begin
                            bad_a = nib_addr; bad_d = nib_data; bad_ea = e.a; bad_ed = e.d;
                        end
                        errs++;
                    end
                end
            end
            if (done) begin got_done = 1; busy_d = busy; end
        end
        start = 1'b0;
        n_checks++;
        if (got_done !== 1'b1) $display("FAIL done_seen: no done within %0d cycles", cycles);
        else n_pass++;
        n_checks++;
        if (cycles > 11000) $display("FAIL done_latency: got %0d cycles, limit 11000", cycles);
        else n_pass++;
        n_checks++;
        if (n_wr !== 6656) $display("FAIL write_count: got %0d expected 6656", n_wr);
        else n_pass++;
        n_checks++;
        if (errs !== 0)
            $display("FAIL write_stream: %0d bad writes, first got a=%0d d=%h expected a=%0d d=%h",
                     errs, bad_a, bad_d, bad_ea, bad_ed);
        else n_pass++;
        n_checks++;
        if (last_we !== cycles - 1)
            $display("FAIL done_after_last_write: last write cycle %0d done cycle %0d", last_we, cycles);
        else n_pass++;
        n_checks++;
        if (busy1 !== 1'b1) $display("FAIL busy_after_start: got %b expected 1", busy1);
        else n_pass++;
        n_checks++;
        if (busy_d !== 1'b0) $display("FAIL busy_at_done: got %b expected 0", busy_d);
        else n_pass++;
        if (poke_done) begin
            start = 1'b1; track = 6'd5;
            @(posedge clk_sys);
            #1;
            start = 1'b0;
        end
        @(negedge clk_sys);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || nib_we !== 1'b0)
            $display("FAIL idle_after_done: busy=%b done=%b nib_we=%b expected 0 0 0", busy, done, nib_we);
        else n_pass++;
    endtask

    task automatic check_seq(input logic [63:0] exp_seq);
        logic [63:0] seq;
        seq = '0;
        foreach (lsq[i]) seq = {seq[59:0], lsq[i]};
        n_checks++;
        if (lsq.size() != 16 || seq !== exp_seq)
            $display("FAIL sector_order: got %0d reads seq=%h expected 16 seq=%h", lsq.size(), seq, exp_seq);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; track = 6'd0; volume = 8'd0; po_order = 1'b0;
        src_data = 8'd0;
        repeat (3) @(negedge clk_sys);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_status: busy=%b done=%b expected 0 0", busy, done);
        else n_pass++;
        n_checks++;
        if (nib_we !== 1'b0) $display("FAIL reset_we: got %b expected 0", nib_we);
        else n_pass++;
        n_checks++;
        if (nib_addr !== 13'd0 || src_addr !== 12'd0)
            $display("FAIL reset_addr: nib_addr=%0d src_addr=%0d expected 0 0", nib_addr, src_addr);
        else n_pass++;
        reset = 1'b0;
    endtask

    // Zero source, vol 254, track 0, ProDOS order; starts the very edge reset is released.
    task automatic test_zero_track();
        logic [111:0] hdr;
        int n96;
        for (int i = 0; i < 4096; i++) src_mem[i] = 8'h00;
        do_track(6'd0, 8'hFE, 1'b1, 1'b0, 1'b0);
        hdr = '0;
        for (int i = 45; i <= 58; i++) hdr = {hdr[103:0], trk_mem[i]};
        n_checks++;
        if (hdr !== 112'hD5AA96FFFEAAAAAAAAFFFEDEAAEB)
            $display("FAIL zero_header: got %h expected D5AA96FFFEAAAAAAAAFFFEDEAAEB", hdr);
        else n_pass++;
        n96 = 0;
        for (int i = 70; i <= 412; i++) if (trk_mem[i] == 8'h96) n96++;
        n_checks++;
        if (n96 !== 343) $display("FAIL zero_data: got %0d bytes of 96 expected 343", n96);
        else n_pass++;
        n_checks++;
        if ({trk_mem[468], trk_mem[469], trk_mem[470], trk_mem[471]} !== 32'hAAABFFFF)
            $display("FAIL sector1_fields: got %h%h%h%h expected AAABFFFF",
                     trk_mem[468], trk_mem[469], trk_mem[470], trk_mem[471]);
        else n_pass++;
        check_seq(64'h08192A3B4C5D6E7F);
    endtask

    // One set byte per sector: 01 in logical 0 (phys 0), FC in logical 7 (phys 1, DOS).
    task automatic test_single_byte();
        int n96;
        for (int i = 0; i < 4096; i++) src_mem[i] = 8'h00;
        src_mem[0] = 8'h01;
        src_mem[12'h700] = 8'hFC;
        do_track(6'd0, 8'hFE, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({trk_mem[70], trk_mem[71]} !== 16'h9A9A)
            $display("FAIL byte01_lead: got %h%h expected 9A9A", trk_mem[70], trk_mem[71]);
        else n_pass++;
        n96 = 0;
        for (int i = 72; i <= 412; i++) if (trk_mem[i] == 8'h96) n96++;
        n_checks++;
        if (n96 !== 341) $display("FAIL byte01_rest: got %0d bytes of 96 expected 341", n96);
        else n_pass++;
        n_checks++;
        if ({trk_mem[572], trk_mem[573], trk_mem[828]} !== 24'hFFFF96)
            $display("FAIL byteFC: got %h%h%h expected FFFF96", trk_mem[572], trk_mem[573], trk_mem[828]);
        else n_pass++;
        check_seq(64'h07E6D5C4B3A2918F);
    endtask

    // Random data; start pulsed mid-track with track 5 and again in the done cycle.
    task automatic test_busy_start();
        for (int i = 0; i < 4096; i++) src_mem[i] = 8'($urandom);
        do_track(6'd3, 8'($urandom), 1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({trk_mem[50], trk_mem[51]} !== 16'hABAB)
            $display("FAIL track_field: got %h%h expected ABAB", trk_mem[50], trk_mem[51]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4096; i++) src_mem[i] = 8'($urandom);
        do_track(6'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        int n_wr, cycles, post_wr, post_busy;
        for (int i = 0; i < 4096; i++) src_mem[i] = 8'($urandom);
        track = 6'd9; volume = 8'h33; po_order = 1'b0; start = 1'b1;
        @(posedge clk_sys);
        #1;
        start = 1'b0;
        n_wr = 0; cycles = 0;
        while (n_wr < 3000 && cycles < 8000) begin
            @(negedge clk_sys);
            cycles++;
            if (nib_we) n_wr++;
        end
        n_checks++;
        if (n_wr !== 3000) $display("FAIL reach_3000: got %0d writes expected 3000", n_wr);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (nib_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL midreset_status: nib_we=%b busy=%b done=%b expected 0 0 0", nib_we, busy, done);
        else n_pass++;
        n_checks++;
        if (nib_addr !== 13'd0 || src_addr !== 12'd0)
            $display("FAIL midreset_addr: nib_addr=%0d src_addr=%0d expected 0 0", nib_addr, src_addr);
        else n_pass++;
        post_wr = 0; post_busy = 0;
        repeat (20) begin
            @(negedge clk_sys);
            if (nib_we) post_wr++;
            if (busy) post_busy++;
        end
        reset = 1'b0;
        repeat (50) begin
            @(negedge clk_sys);
            if (nib_we) post_wr++;
            if (busy) post_busy++;
        end
        n_checks++;
        if (post_wr !== 0 || post_busy !== 0)
            $display("FAIL after_reset_quiet: writes=%0d busy_cycles=%0d expected 0 0", post_wr, post_busy);
        else n_pass++;
        do_track(6'd9, 8'h33, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero_track();
        test_single_byte();
        test_busy_start();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
